// File: rtl/exe_multdiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine for the EXE stage.
// Produces HI/LO results, raises a stall while busy, and honours flush aborts.
module exe_multdiv_unit #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_ITERS  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  EXE_MultDivOp,
    input  logic [31:0] EXE_rs_data,
    input  logic [31:0] EXE_rt_data,
    input  logic        EXE_Wr,
    input  logic        MultDiv_Abort,
    output logic        DIVMULTBusy,
    output logic        MultDiv_Valid,
    output logic [31:0] MultDiv_Hi,
    output logic [31:0] MultDiv_Lo
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;

    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

    state_t      state, state_next;
    logic [5:0]  count;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] dvsr;
    logic [63:0] acc;
    logic [31:0] hi_q, lo_q;

    logic        op_mul, op_div, op_signed, start;
    logic [31:0] rs_mag, rt_mag;
    logic [63:0] mul_mag;
    logic [32:0] rem_sh, diff;
    logic [63:0] acc_iter;
    logic [63:0] prod_fixed;
    logic [31:0] quo_fixed, rem_fixed;

    always_comb begin
        op_mul    = (EXE_MultDivOp == OP_MULT) || (EXE_MultDivOp == OP_MULTU);
        op_div    = (EXE_MultDivOp == OP_DIV)  || (EXE_MultDivOp == OP_DIVU);
        op_signed = (EXE_MultDivOp == OP_MULT) || (EXE_MultDivOp == OP_DIV);
        start     = (state == IDLE) && (op_mul || op_div) && !MultDiv_Abort && !rst;
        rs_mag    = (op_signed && EXE_rs_data[31]) ? -EXE_rs_data : EXE_rs_data;
        rt_mag    = (op_signed && EXE_rt_data[31]) ? -EXE_rt_data : EXE_rt_data;
        mul_mag   = {32'b0, rs_mag} * {32'b0, rt_mag};
    end

    // acc holds {remainder, quotient}; one restoring step shifts left and trial-subtracts
    always_comb begin
        rem_sh   = {acc[63:32], acc[31]};
        diff     = rem_sh - {1'b0, dvsr};
        acc_iter = diff[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                            : {diff[31:0],   acc[30:0], 1'b1};
        prod_fixed = neg_q ? -acc : acc;
        quo_fixed  = neg_q ? -acc_iter[31:0]  : acc_iter[31:0];
        rem_fixed  = neg_r ? -acc_iter[63:32] : acc_iter[63:32];
    end

    always_comb begin
        state_next    = state;
        DIVMULTBusy   = 1'b0;
        MultDiv_Valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    DIVMULTBusy = 1'b1;
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (MultDiv_Abort) begin
                    state_next = IDLE;
                end else begin
                    DIVMULTBusy = 1'b1;
                    if (count == '0) state_next = DONE;
                end
            end
            DONE: begin
                if (MultDiv_Abort) begin
                    state_next = IDLE;
                end else begin
                    MultDiv_Valid = 1'b1;
                    if (EXE_Wr) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dvsr   <= '0;
            acc    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                count  <= op_div ? DIV_LAST : MUL_LAST;
                is_div <= op_div;
                neg_q  <= op_signed && (EXE_rs_data[31] ^ EXE_rt_data[31]);
                neg_r  <= op_signed && EXE_rs_data[31];
                dvsr   <= rt_mag;
                acc    <= op_div ? {32'b0, rs_mag} : mul_mag;
            end else if (state == RUN && !MultDiv_Abort) begin
                count <= count - 6'd1;
                if (is_div) acc <= acc_iter;
                // results land only on the final, non-aborted RUN cycle
                if (count == '0) begin
                    if (is_div) begin
                        hi_q <= rem_fixed;
                        lo_q <= quo_fixed;
                    end else begin
                        hi_q <= prod_fixed[63:32];
                        lo_q <= prod_fixed[31:0];
                    end
                end
            end
        end
    end

    assign MultDiv_Hi = hi_q;
    assign MultDiv_Lo = lo_q;

endmodule

// File: tb/tb_exe_multdiv_unit.sv
// Self-checking bench for exe_multdiv_unit: directed vectors, randomized ops
// against an arithmetic reference model, and abort/stall/reset sequences.
module tb_exe_multdiv_unit;

    localparam int unsigned MUL_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        wr, abort;
    logic        busy, valid;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    exe_multdiv_unit #(.MUL_CYCLES(MUL_CYCLES), .DIV_ITERS(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .EXE_MultDivOp (op),
        .EXE_rs_data   (rs),
        .EXE_rt_data   (rt),
        .EXE_Wr        (wr),
        .MultDiv_Abort (abort),
        .DIVMULTBusy   (busy),
        .MultDiv_Valid (valid),
        .MultDiv_Hi    (hi),
        .MultDiv_Lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: {hi, lo} computed directly from the arithmetic definitions
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd1: begin q = sa * sb; qv = q; return qv; end
            3'd2: return {32'b0, a} * {32'b0, b};
            3'd3: begin
                if (b == 0) begin
                    qv = a[31] ? 64'd1 : 64'hFFFFFFFF;
                    return {a, qv[31:0]};
                end
                q = sa / sb; r = sa % sb; qv = q; rv = r;
                return {rv[31:0], qv[31:0]};
            end
            3'd4: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int stall, input logic [63:0] exp, input string nm);
        int n;
        int exp_cycles;
        exp_cycles = (o >= 3'd3) ? 33 : int'(MUL_CYCLES) + 1;
        @(negedge clk);
        op = o; rs = a; rt = b; wr = 1'b0;
        #1;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
            op = 3'd0; rs = $urandom; rt = $urandom;
        end
        op = 3'd0;
        check({nm, " busy_cycles"}, 64'(n), 64'(exp_cycles));
        check({nm, " valid"}, {63'b0, valid}, 64'd1);
        check({nm, " hilo"}, {hi, lo}, exp);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({nm, " stall_hold"}, {busy, valid, hi, lo}, {2'b01, exp});
        end
        @(negedge clk); wr = 1'b1;
        @(posedge clk); #1; wr = 1'b0;
        check({nm, " release"}, {62'b0, busy, valid}, 64'd0);
    endtask

    initial begin
        vec_t vecs[9];
        int   vcnt;
        vecs[0] = '{3'd1, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1};
        vecs[1] = '{3'd4, 32'd100,      32'd7,        64'h00000002_0000000E};
        vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD};
        vecs[3] = '{3'd4, 32'd5,        32'd0,        64'h00000005_FFFFFFFF};
        vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
        vecs[5] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[6] = '{3'd3, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
        vecs[7] = '{3'd3, 32'hFFFFFFF9, 32'd0,        64'hFFFFFFF9_00000001};
        vecs[8] = '{3'd1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};

        rst = 1'b1; op = 3'd0; rs = '0; rt = '0; wr = 1'b0; abort = 1'b0;
        #2;
        check("reset_outputs", {30'b0, busy, valid, hi, lo}, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i == 0) ? 4 : 0, vecs[i].res,
                   $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            int          sel;
            o = 3'($urandom_range(1, 4));
            a = $urandom; b = $urandom; sel = $urandom_range(0, 7);
            if (sel == 0) b = '0;
            if (sel == 1) a = 32'h80000000;
            if (sel == 2) b = '1;
            if (sel == 3) b = b >> $urandom_range(8, 28);
            run_op(o, a, b, $urandom_range(0, 2), model(o, a, b), $sformatf("rand%0d", i));
        end

        // abort at RUN cycle 10 of a divide
        @(negedge clk); op = 3'd4; rs = 32'd1000; rt = 32'd3;
        @(posedge clk); #1; op = 3'd0;
        repeat (9) @(posedge clk);
        #1; abort = 1'b1; #1;
        check("abort_run_busy_valid", {62'b0, busy, valid}, 64'd0);
        @(posedge clk); #1; abort = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid || busy) vcnt++;
        end
        check("abort_run_no_valid", 64'(vcnt), 64'd0);
        run_op(3'd4, 32'd9, 32'd3, 0, 64'h00000000_00000003, "after_abort");

        // abort in IDLE suppresses the start
        @(negedge clk); op = 3'd4; rs = 32'd50; rt = 32'd5; abort = 1'b1; #1;
        check("abort_idle_busy", {63'b0, busy}, 64'd0);
        @(posedge clk); #1; op = 3'd0; abort = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid || busy) vcnt++;
        end
        check("abort_idle_no_run", 64'(vcnt), 64'd0);

        // abort while sitting in DONE
        @(negedge clk); op = 3'd2; rs = 32'd6; rt = 32'd7;
        @(posedge clk); #1; op = 3'd0;
        vcnt = 0;
        while (!valid && vcnt < 50) begin @(posedge clk); #1; vcnt++; end
        check("done_reached", {63'b0, valid}, 64'd1);
        abort = 1'b1; #1;
        check("abort_done_valid", {62'b0, busy, valid}, 64'd0);
        @(posedge clk); #1; abort = 1'b0;
        check("abort_done_idle", {62'b0, busy, valid}, 64'd0);

        // reset pulse at RUN cycle 5
        @(negedge clk); op = 3'd4; rs = 32'd100; rt = 32'd7;
        @(posedge clk); #1; op = 3'd0;
        repeat (4) @(posedge clk);
        #1; rst = 1'b1; #1;
        check("reset_midrun", {30'b0, busy, valid, hi, lo}, 64'd0);
        @(negedge clk); rst = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid || busy) vcnt++;
        end
        check("reset_no_resume", 64'(vcnt), 64'd0);
        run_op(3'd1, 32'hFFFFFFFD, 32'd5, 1, 64'hFFFFFFFF_FFFFFFF1, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
